// File: rtl/fifo_sync_circular_flags.sv
// fifo_sync_circular_flags
//
// Single-clock circular FIFO. It keeps its fill level in a dedicated counter
// and drives every status flag from a register. The flags are computed from
// the next level, so they always agree with level_out in the same cycle.
//
// Optional build macro:
//   FIFO_SYNC_FWFT_EN  When defined, the FIFO runs in first-word-fall-through
//                      mode: data_read_out shows memory[rd_ptr] whenever the
//                      FIFO is not empty, and read_in pops that head word.
//                      When undefined (the default), each accepted read
//                      registers the head word, which appears one cycle later.
//
// Parameters:
//   WIDTH          data word width in bits (>= 1)
//   DEPTH          number of entries (a power of two, >= 2)
//   AFULL_THRESH   almost_full_out is asserted when level >= AFULL_THRESH (1..DEPTH)
//   AEMPTY_THRESH  almost_empty_out is asserted when level <= AEMPTY_THRESH (0..DEPTH-1)
//
// Ports:
//   clk               clock; all state changes on the rising edge
//   rst_in            asynchronous, active-high reset
//   flush_in          synchronous flush; takes priority over read and write
//   clear_err_in      synchronous clear of the sticky error flags
//   write_in          write request
//   data_write_in     write data
//   read_in           read request
//   data_read_out     read data (registered, or the head word in FWFT mode)
//   full_out          level == DEPTH
//   empty_out         level == 0
//   almost_full_out   level >= AFULL_THRESH
//   almost_empty_out  level <= AEMPTY_THRESH
//   level_out         number of stored words
//   overflow_out      sticky: a write was attempted while full and was not accepted
//   underflow_out     sticky: a read was attempted while empty

module fifo_sync_circular_flags #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned AFULL_THRESH  = 12,
  parameter int unsigned AEMPTY_THRESH = 4
) (
  input  logic                     clk,
  input  logic                     rst_in,
  input  logic                     flush_in,
  input  logic                     clear_err_in,
  input  logic                     write_in,
  input  logic [WIDTH-1:0]         data_write_in,
  input  logic                     read_in,
  output logic [WIDTH-1:0]         data_read_out,
  output logic                     full_out,
  output logic                     empty_out,
  output logic                     almost_full_out,
  output logic                     almost_empty_out,
  output logic [$clog2(DEPTH):0]   level_out,
  output logic                     overflow_out,
  output logic                     underflow_out
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned LevelW = PtrW + 1;

  typedef logic [PtrW-1:0]   ptr_t;
  typedef logic [LevelW-1:0] level_t;

  localparam level_t LevelFull   = level_t'(DEPTH);
  localparam level_t LevelAfull  = level_t'(AFULL_THRESH);
  localparam level_t LevelAempty = level_t'(AEMPTY_THRESH);

  // Reject configurations that would break pointer wrap or the flag thresholds.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("WIDTH must be at least 1");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("AFULL_THRESH must lie in 1..DEPTH");
  end
  if (AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("AEMPTY_THRESH must lie in 0..DEPTH-1");
  end

  // Storage. It is not reset, so its contents are undefined after reset.
  logic [WIDTH-1:0] mem_q [DEPTH];

  ptr_t   wr_ptr_q, wr_ptr_d;
  ptr_t   rd_ptr_q, rd_ptr_d;
  level_t level_q,  level_d;

  logic full_q,   full_d;
  logic empty_q,  empty_d;
  logic afull_q,  afull_d;
  logic aempty_q, aempty_d;
  logic ovf_q,    ovf_d;
  logic udf_q,    udf_d;

  logic rd_accept;
  logic wr_accept;
  logic ovf_event;
  logic udf_event;

  // Request qualification. A flush suppresses both transfers and both error
  // events in the same cycle. A write to a full FIFO still succeeds if a read
  // is accepted in the same cycle, because that read frees a slot.
  always_comb begin
    rd_accept = read_in && !empty_q && !flush_in;
    wr_accept = write_in && !flush_in && (!full_q || rd_accept);
    ovf_event = write_in && !flush_in && full_q && !rd_accept;
    udf_event = read_in && !flush_in && empty_q;
  end

  // Next-state computation for the pointers, the level and the flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap without a compare.
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_q + ptr_t'(1);
      end
      if (rd_accept) begin
        rd_ptr_d = rd_ptr_q + ptr_t'(1);
      end
      unique case ({wr_accept, rd_accept})
        2'b10:   level_d = level_q + level_t'(1);
        2'b01:   level_d = level_q - level_t'(1);
        default: level_d = level_q;
      endcase
    end

    // The flags follow the next level, so they never lag level_out.
    full_d   = (level_d == LevelFull);
    empty_d  = (level_d == '0);
    afull_d  = (level_d >= LevelAfull);
    aempty_d = (level_d <= LevelAempty);

    // Sticky error flags. A new event wins over a clear in the same cycle.
    ovf_d = (ovf_q && !clear_err_in) || ovf_event;
    udf_d = (udf_q && !clear_err_in) || udf_event;
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= data_write_in;
    end
  end

`ifdef FIFO_SYNC_FWFT_EN
  // The head word is shown continuously. Its value is meaningless while empty.
  assign data_read_out = mem_q[rd_ptr_q];
`else
  logic [WIDTH-1:0] rdata_q;

  // The word appears one cycle after it is read, and is held between reads.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      rdata_q <= '0;
    end else if (rd_accept) begin
      rdata_q <= mem_q[rd_ptr_q];
    end
  end

  assign data_read_out = rdata_q;
`endif

  assign full_out         = full_q;
  assign empty_out        = empty_q;
  assign almost_full_out  = afull_q;
  assign almost_empty_out = aempty_q;
  assign level_out        = level_q;
  assign overflow_out     = ovf_q;
  assign underflow_out    = udf_q;

endmodule

// File: tb/tb_fifo_sync_circular_flags.sv
module tb_fifo_sync_circular_flags;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 16;
  localparam int unsigned AF = 12;
  localparam int unsigned AE = 4;
  localparam int unsigned LW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          clr = 1'b0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic [W-1:0]  din = '0;

  logic [W-1:0]  dout;
  logic          full, empty, afull, aempty, ovf, udf;
  logic [LW-1:0] level;

  fifo_sync_circular_flags #(
    .WIDTH        (W),
    .DEPTH        (D),
    .AFULL_THRESH (AF),
    .AEMPTY_THRESH(AE)
  ) dut (
    .clk             (clk),
    .rst_in          (rst),
    .flush_in        (flush),
    .clear_err_in    (clr),
    .write_in        (wr),
    .data_write_in   (din),
    .read_in         (rd),
    .data_read_out   (dout),
    .full_out        (full),
    .empty_out       (empty),
    .almost_full_out (afull),
    .almost_empty_out(aempty),
    .level_out       (level),
    .overflow_out    (ovf),
    .underflow_out   (udf)
  );

  always #5 clk = ~clk;

  // Behavioural reference: a queue holding the stored words, plus the
  // registered read word and the two sticky error bits.
  logic [W-1:0] q[$];
  logic [W-1:0] m_dout;
  logic         m_ovf;
  logic         m_udf;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, "/level"},  32'(level),  32'(n));
    chk({tag, "/full"},   32'(full),   32'(n == D));
    chk({tag, "/empty"},  32'(empty),  32'(n == 0));
    chk({tag, "/afull"},  32'(afull),  32'(n >= AF));
    chk({tag, "/aempty"}, 32'(aempty), 32'(n <= AE));
    chk({tag, "/ovf"},    32'(ovf),    32'(m_ovf));
    chk({tag, "/udf"},    32'(udf),    32'(m_udf));
`ifdef FIFO_SYNC_FWFT_EN
    if (n > 0) chk({tag, "/head"}, 32'(dout), 32'(q[0]));
`else
    chk({tag, "/dout"}, 32'(dout), 32'(m_dout));
`endif
  endtask

  // Applies one cycle of stimulus, steps the model, and then checks the outputs
  // 1 time unit after the rising edge.
  task automatic step(input bit w, input logic [W-1:0] d, input bit r, input bit f,
                      input bit c, input string tag);
    bit rd_ok, wr_ok, ovf_ev, udf_ev;
    rd_ok = 0; wr_ok = 0; ovf_ev = 0; udf_ev = 0;
    if (f) begin
      q.delete();
    end else begin
      rd_ok  = r && (q.size() > 0);
      wr_ok  = w && ((q.size() < D) || rd_ok);
      ovf_ev = w && !wr_ok;
      udf_ev = r && (q.size() == 0);
      if (rd_ok) m_dout = q.pop_front();
      if (wr_ok) q.push_back(d);
    end
    m_ovf = (m_ovf && !c) || ovf_ev;
    m_udf = (m_udf && !c) || udf_ev;
    wr = w; din = d; rd = r; flush = f; clr = c;
    @(posedge clk);
    #1;
    wr = 0; rd = 0; flush = 0; clr = 0;
    check_all(tag);
  endtask

  // Asserts reset in the middle of a cycle and checks the outputs before the next edge.
  task automatic async_reset(input string tag);
    rst = 1'b1;
    #1;
    q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    check_all(tag);
    chk({tag, "/dout0"}, 32'(dout), 32'd0);
    wr = 0; rd = 0; flush = 0; clr = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] pat [16];
    logic [W-1:0] v;
    int pw, pr;

    pat[0] = 8'h23; pat[1] = 8'h25; pat[2] = 8'hff;
    for (int i = 3; i < 15; i++) pat[i] = W'(8'h30 + i);
    pat[15] = 8'h10;

    m_dout = '0; m_ovf = 0; m_udf = 0;

    // Reset state, checked while reset is held across an edge
    @(posedge clk);
    #1;
    check_all("reset");
    chk("reset/dout0", 32'(dout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: fill to 16 words, then one extra write is dropped
    for (int i = 0; i < 16; i++) step(1, pat[i], 0, 0, 0, "fill");
    step(1, 8'hEE, 0, 0, 0, "fill_extra");
    chk("t1/full", 32'(full), 32'd1);
    chk("t1/ovf", 32'(ovf), 32'd1);

    // 2: drain all words in order, then read once more while empty
    for (int i = 0; i < 16; i++) begin
      step(0, '0, 1, 0, 0, "drain");
`ifndef FIFO_SYNC_FWFT_EN
      chk("t2/order", 32'(dout), 32'(pat[i]));
`endif
    end
    step(0, '0, 1, 0, 0, "drain_extra");
    chk("t2/udf", 32'(udf), 32'd1);
`ifndef FIFO_SYNC_FWFT_EN
    chk("t2/hold", 32'(dout), 32'h10);
`endif
    step(0, '0, 0, 0, 1, "clear1");

    // 3: from full, read and write together across the pointer wrap
    for (int i = 0; i < 16; i++) step(1, W'(i), 0, 0, 0, "fill3");
    for (int i = 0; i < 20; i++) step(1, W'(8'h80 + i), 1, 0, 0, "rw_full");
    chk("t3/level", 32'(level), 32'd16);
    chk("t3/ovf", 32'(ovf), 32'd0);
    step(0, '0, 0, 1, 0, "flush3");

    // 4: read and write together on an empty FIFO
    step(1, 8'hAA, 1, 0, 0, "rw_empty");
    chk("t4/level", 32'(level), 32'd1);
    chk("t4/udf", 32'(udf), 32'd1);
    step(0, '0, 0, 0, 1, "clear4");
    chk("t4/udf_clr", 32'(udf), 32'd0);
    step(0, '0, 1, 0, 0, "read4");
`ifndef FIFO_SYNC_FWFT_EN
    chk("t4/aa", 32'(dout), 32'hAA);
`endif

    // A clear and a new error in the same cycle: the new error wins
    step(0, '0, 1, 0, 1, "clr_vs_set");
    chk("t4b/udf", 32'(udf), 32'd1);

    // 5: a flush wins over a same-cycle write; then an asynchronous reset mid-burst
    for (int i = 0; i < 5; i++) step(1, W'($urandom), 0, 0, 0, "fill5");
    step(1, 8'h77, 0, 1, 0, "flush_wr");
    chk("t5/level", 32'(level), 32'd0);
    chk("t5/empty", 32'(empty), 32'd1);
    for (int i = 0; i < 3; i++) step(1, W'($urandom), 0, 0, 0, "burst5");
    wr = 1; din = 8'h99; rd = 1;
    async_reset("async_rst");

`ifdef FIFO_SYNC_FWFT_EN
    // 6: first-word-fall-through
    step(1, 8'h5C, 0, 0, 0, "fwft_wr");
    chk("t6/empty", 32'(empty), 32'd0);
    chk("t6/head", 32'(dout), 32'h5C);
    step(0, '0, 1, 0, 0, "fwft_rd");
    chk("t6/empty_after", 32'(empty), 32'd1);
`endif

    // Randomized traffic. The write/read bias alternates so the FIFO spends
    // time near full and near empty.
    for (int blk = 0; blk < 10; blk++) begin
      pw = blk[0] ? 25 : 80;
      pr = blk[0] ? 80 : 25;
      for (int i = 0; i < 60; i++) begin
        bit w, r, f, c;
        w = ($urandom_range(0, 99) < pw);
        r = ($urandom_range(0, 99) < pr);
        f = ($urandom_range(0, 63) == 0);
        c = !f && ($urandom_range(0, 31) == 0);
        v = W'($urandom);
        step(w, v, r, f, c, "rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
